// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Optional divider datapath is built only when MDU_DIV_EN is defined.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_t;

    localparam int          MDU_ITER    = 32;
    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] mdu_abs(
        input logic [31:0] v,
        input logic        neg
    );
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Only compiled when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvsr_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvsr_i};
    // A borrow out of the trial subtraction means the divisor did not fit.
    assign q_o     = ~diff[W];
    assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit; 34-edge fixed latency per op.
// Define MDU_DIV_EN to build the DIV/DIVU datapath.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [5:0] LAST_CNT = 6'(MDU_ITER - 1);

    mdu_state_t          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    mdu_op_t             op_t;
    logic                is_div;
    logic                sgn_a, sgn_b;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic                op_ok;
    logic                accept;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_nxt;
    logic [2*DATA_W-1:0] step_nxt;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    assign op_t   = mdu_op_t'(op);
    assign is_div = (op_t == OP_DIV) || (op_t == OP_DIVU);
    assign sgn_a  = ((op_t == OP_MULT) || (op_t == OP_DIV)) & srcA[DATA_W-1];
    assign sgn_b  = ((op_t == OP_MULT) || (op_t == OP_DIV)) & srcB[DATA_W-1];
    assign abs_a  = mdu_abs(srcA, sgn_a);
    assign abs_b  = mdu_abs(srcB, sgn_b);
    assign accept = (state_q == S_IDLE) && start && op_ok;

    // Multiplier sits in acc low half and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                   + {1'b0, (acc_q[0] ? opnd_q : {DATA_W{1'b0}})};
    assign mul_nxt = {mul_sum, acc_q[DATA_W-1:1]};

    assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    logic              is_div_q;
    logic              neg_r_q;
    logic              div0_q;
    logic [DATA_W-1:0] raw_a_q;
    logic [DATA_W-1:0] rem_nxt;
    logic              q_bit;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign op_ok = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            raw_a_q  <= '0;
        end else if (accept) begin
            is_div_q <= is_div;
            neg_r_q  <= sgn_a;
            div0_q   <= (srcB == '0);
            raw_a_q  <= srcA;
        end
    end

    // Divide: acc = {remainder, dividend/quotient}.
    mdu_div_step #(.W(DATA_W)) u_div_step (
        .rem_i  (acc_q[2*DATA_W-1:DATA_W]),
        .bit_i  (acc_q[DATA_W-1]),
        .dvsr_i (opnd_q),
        .rem_o  (rem_nxt),
        .q_o    (q_bit)
    );

    assign step_nxt = is_div_q ? {rem_nxt, acc_q[DATA_W-2:0], q_bit}
                               : mul_nxt;
    assign quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W]
                              : acc_q[2*DATA_W-1:DATA_W];
    assign fix_lo   = !is_div_q ? prod_fix[DATA_W-1:0]
                    : div0_q    ? MDU_DIV0_LO : quo_fix;
    assign fix_hi   = !is_div_q ? prod_fix[2*DATA_W-1:DATA_W]
                    : div0_q    ? raw_a_q : rem_fix;
`else
    assign op_ok    = ~is_div;
    assign step_nxt = mul_nxt;
    assign fix_lo   = prod_fix[DATA_W-1:0];
    assign fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    neg_d   = sgn_a ^ sgn_b;
                    opnd_d  = is_div ? abs_b : abs_a;
                    acc_d   = {{DATA_W{1'b0}}, (is_div ? abs_a : abs_b)};
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                acc_d = step_nxt;
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// DIV cases run when MDU_DIV_EN is defined; otherwise the disabled-divider case runs.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at edge 1 and report the edge after which done was seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    endtask

    task automatic test_mthi();
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h123;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        checks++; if (hi !== 32'h123) begin errors++; $display("FAIL mthi_hi: got %h want 00000123", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo: got %h want 0", lo); end
    endtask

    task automatic test_multu_max();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (e == 20) begin
                checks++;
                if (hi !== 32'h123) begin errors++; $display("FAIL multu_hi_stable: got %h want 00000123", hi); end
            end
            if (e < 33) @(posedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL multu_busy_run: got %0d bad cycles want 0", bad); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_end: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_signed();
        int lat;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL mult_lat: got %0d want 34", lat); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b01; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; srcA = 32'd7; srcB = 32'd9;
        @(posedge clk);
        #1 begin hi_we = 1'b0; start = 1'b0; end
        @(negedge clk);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ign_hi_mid: got %h want ffffffff", hi); end
        lat = -1;
        for (int e = 11; e <= 50; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin lat = e; break; end
        end
        checks++; if (lat != 34) begin errors++; $display("FAIL ign_lat: got %0d want 34", lat); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ign_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd30) begin errors++; $display("FAIL ign_lo: got %h want 0000001e", lo); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_requeue: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b01; srcA = 32'd2; srcB = 32'd3;
        @(posedge clk);
        #1 begin srcA = 32'd4; srcB = 32'd5; end
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = e; break; end
            @(posedge clk);
        end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_lat1: got %0d want 34", lat); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo1: got %h want 00000006", lo); end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
        lat = -1;
        for (int e = 2; e <= 50; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin lat = e; break; end
        end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_lat2: got %0d want 34", lat); end
        checks++; if (lo !== 32'd20) begin errors++; $display("FAIL b2b_lo2: got %h want 00000014", lo); end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int lat;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_s_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_s_hi: got %h want ffffffff", hi); end
        run_op(2'b11, 32'd100, 32'd11, lat);
        checks++; if (lo !== 32'd9) begin errors++; $display("FAIL divu_lo: got %h want 00000009", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 00000001", hi); end
        run_op(2'b11, 32'd100, 32'd0, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL div0_lat: got %0d want 34", lat); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL div0_hi: got %h want 00000064", hi); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divov_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divov_hi: got %h want 0", hi); end
    endtask
`endif

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'hFFFF_FFFD; srcB = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen); end
    endtask

`ifndef MDU_DIV_EN
    task automatic test_div_disabled();
        int seen;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
        @(posedge clk);
        #1 begin hi_we = 1'b0; lo_we = 1'b0; end
        @(negedge clk);
        checks++; if (hi !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtboth_hi: got %h want a5a50f0f", hi); end
        checks++; if (lo !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mtboth_lo: got %h want a5a50f0f", lo); end
        start = 1'b1; op = 2'b10; srcA = 32'd10; srcB = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy: got %b want 0", busy); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL nodiv_done: got %0d active cycles want 0", seen); end
        checks++; if (hi !== 32'hA5A5_0F0F) begin errors++; $display("FAIL nodiv_hi: got %h want a5a50f0f", hi); end
        checks++; if (lo !== 32'hA5A5_0F0F) begin errors++; $display("FAIL nodiv_lo: got %h want a5a50f0f", lo); end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_mthi();
        test_multu_max();
        test_mult_signed();
        test_ignore_busy();
        test_back_to_back();
`ifdef MDU_DIV_EN
        test_div();
`endif
        test_reset_mid();
`ifndef MDU_DIV_EN
        test_div_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
